// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared types and constants for the IFU/LSU mmio arbiter:
//             state encodings, owner codes, widths and the IFU width-op.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int c_addr_w = 64;
  localparam int c_data_w = 64;
  localparam int c_wop_w  = 4;

  // Width-op used for every instruction fetch (one-hot "word").
  localparam logic [c_wop_w-1:0] c_wop_word = 4'b0100;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  // The requester that is not o; used for round-robin tie breaking.
  function automatic arb_owner_e other_owner(input arb_owner_e o);
    return (o == OWN_IFU) ? OWN_LSU : OWN_IFU;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the IFU request/response, LSU request/response and
//             mmio strobe/data signals seen by the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int WOP_W  = c_wop_w
);
  // IFU side
  logic              ifu_valid;
  logic              ifu_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rvalid;
  logic              ifu_rready;
  logic [DATA_W-1:0] ifu_rdata;
  // LSU side
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [WOP_W-1:0]  lsu_wop;
  logic              lsu_rvalid;
  logic              lsu_rready;
  logic [DATA_W-1:0] lsu_rdata;
  // mmio side
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ren;
  logic              mem_wen;
  logic [WOP_W-1:0]  wdt_op;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  ifu_valid, ifu_addr, ifu_rready,
    input  lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wop, lsu_rready,
    input  mem_rdata,
    output ifu_ready, ifu_rvalid, ifu_rdata,
    output lsu_ready, lsu_rvalid, lsu_rdata,
    output mem_raddr, mem_waddr, mem_wdata, mem_ren, mem_wen, wdt_op
  );

  // Environment view (core pipeline + mmio)
  modport master (
    output ifu_valid, ifu_addr, ifu_rready,
    output lsu_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wop, lsu_rready,
    output mem_rdata,
    input  ifu_ready, ifu_rvalid, ifu_rdata,
    input  lsu_ready, lsu_rvalid, lsu_rdata,
    input  mem_raddr, mem_waddr, mem_wdata, mem_ren, mem_wen, wdt_op
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational 2-way round-robin grant. A lone requester wins;
//             on contention the requester that was not granted last wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       i_req0,   // IFU
  input  logic       i_req1,   // LSU
  input  arb_owner_e i_last,
  output logic       o_gnt0,
  output logic       o_gnt1
);

  // Grant decision: single requester wins, ties go to the non-last owner
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_req0 && i_req1) begin
      if (other_owner(i_last) == OWN_IFU) o_gnt0 = 1'b1;
      else                                o_gnt1 = 1'b1;
    end else if (i_req0) begin
      o_gnt0 = 1'b1;
    end else if (i_req1) begin
      o_gnt1 = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares the single mmio port between IFU (read-only) and LSU
//             (read/write). One accepted request -> exactly one one-cycle
//             mmio strobe -> one registered response held until taken.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int WOP_W  = c_wop_w
)(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_e        r_state;
  arb_owner_e        r_last;
  arb_owner_e        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [WOP_W-1:0]  r_wop;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ifu_rvalid;
  logic              r_lsu_rvalid;

  logic              w_gnt_ifu;
  logic              w_gnt_lsu;
  logic              w_idle;
  logic              w_ifu_hs;
  logic              w_lsu_hs;
  logic              w_resp_taken;

  rr_arb2 u_rr_arb2 (
    .i_req0 (bus.ifu_valid),
    .i_req1 (bus.lsu_valid),
    .i_last (r_last),
    .o_gnt0 (w_gnt_ifu),
    .o_gnt1 (w_gnt_lsu)
  );

  // Readies are offered only while idle and only to the arbitration winner;
  // reset is folded in so nothing is accepted while it is asserted.
  assign w_idle        = (r_state == ARB_IDLE) && !rst;
  assign w_ifu_hs      = w_idle && w_gnt_ifu;
  assign w_lsu_hs      = w_idle && w_gnt_lsu;
  assign w_resp_taken  = (r_owner == OWN_IFU) ? bus.ifu_rready : bus.lsu_rready;

  assign bus.ifu_ready  = w_ifu_hs;
  assign bus.lsu_ready  = w_lsu_hs;
  assign bus.ifu_rvalid = r_ifu_rvalid;
  assign bus.lsu_rvalid = r_lsu_rvalid;
  assign bus.ifu_rdata  = r_rdata;
  assign bus.lsu_rdata  = r_rdata;
  assign bus.mem_raddr  = r_addr;
  assign bus.mem_waddr  = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_ren    = r_mem_ren;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.wdt_op     = r_wop;

  // Arbitration FSM with request latches, single-cycle strobes and response regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last       <= OWN_IFU;
      r_owner      <= OWN_IFU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wop        <= '0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_rdata      <= '0;
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_lsu_hs) begin
            r_addr    <= bus.lsu_addr;
            r_wen     <= bus.lsu_wen;
            r_wdata   <= bus.lsu_wdata;
            r_wop     <= bus.lsu_wop;
            r_owner   <= OWN_LSU;
            r_last    <= OWN_LSU;
            r_mem_ren <= !bus.lsu_wen;
            r_mem_wen <= bus.lsu_wen;
            r_state   <= ARB_ACCESS;
          end else if (w_ifu_hs) begin
            // Fetches are word reads; write data register keeps its last value
            r_addr    <= bus.ifu_addr;
            r_wen     <= 1'b0;
            r_wop     <= c_wop_word;
            r_owner   <= OWN_IFU;
            r_last    <= OWN_IFU;
            r_mem_ren <= 1'b1;
            r_mem_wen <= 1'b0;
            r_state   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          // mmio read data is only valid during the strobe cycle; capture it now
          r_mem_ren    <= 1'b0;
          r_mem_wen    <= 1'b0;
          r_rdata      <= r_wen ? '0 : bus.mem_rdata;
          r_ifu_rvalid <= (r_owner == OWN_IFU);
          r_lsu_rvalid <= (r_owner == OWN_LSU);
          r_state      <= ARB_RESP;
        end
        ARB_RESP: begin
          if (w_resp_taken) begin
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_state      <= ARB_IDLE;
          end
        end
        default: begin
          r_mem_ren    <= 1'b0;
          r_mem_wen    <= 1'b0;
          r_ifu_rvalid <= 1'b0;
          r_lsu_rvalid <= 1'b0;
          r_state      <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
